// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake and a one-entry skid buffer.
// Carries {PC+4, instruction}, supports flush with NOP injection and a saturating stall counter.
module if_id_pipe_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic in_xfer;
  logic out_xfer;
  logic head_valid;

  assign head_valid = (state_q != EMPTY);
  assign in_xfer    = in_valid && in_ready_q;
  assign out_xfer   = head_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      // Redirect kills everything; the PC is left as-is, only the instruction becomes a NOP.
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_pc_d    = in_pc_plus4;
            main_instr_d = in_instr;
            state_d      = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_xfer) begin
              main_pc_d    = in_pc_plus4;
              main_instr_d = in_instr;
            end else begin
              main_instr_d = NOP_INSTR;
              state_d      = EMPTY;
            end
          end else if (in_xfer) begin
            skid_pc_d    = in_pc_plus4;
            skid_instr_d = in_instr;
            state_d      = SKID;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            state_d      = FULL;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // in_ready is a flop so fetch never sees a combinational path from out_ready.
  assign in_ready_d = (state_d != SKID);

  always_comb begin
    stall_d = stall_q;
    if (flush || out_xfer) begin
      stall_d = '0;
    end else if (head_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = head_valid;
  assign out_pc_plus4 = main_pc_q;
  assign out_instr    = main_instr_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Randomized + directed bench for if_id_pipe_stage; a FIFO-of-entries model predicts
// handshake, ordering, NOP output and stall counter, checked by a negedge monitor.
module tb_if_id_pipe_stage;

  localparam int          PC_W  = 32;
  localparam int          IW    = 32;
  localparam int          CW    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          SMAX  = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc_plus4;
  logic [31:0]   in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc_plus4;
  logic [31:0]   out_instr;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_pipe_stage #(
    .PC_W(PC_W), .INSTR_W(IW), .NOP_INSTR(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries held by the stage, oldest first.
  logic [63:0] sb_q[$];
  int          stall_m = 0;
  logic        stalled_prev = 1'b0;
  logic [63:0] prev_out;

  always @(negedge clk) begin
    int n;
    logic [63:0] head;
    if (rst) begin
      sb_q.delete();
      stall_m      = 0;
      stalled_prev = 1'b0;
    end else begin
      n = sb_q.size();
      chk("out_valid", 64'(out_valid), 64'(n > 0));
      chk("in_ready", 64'(in_ready), 64'(n < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      if (n == 0) begin
        chk("nop_instr", 64'(out_instr), 64'(NOP));
      end else begin
        head = sb_q[0];
        chk("head_pc", 64'(out_pc_plus4), 64'(head[63:32]));
        chk("head_instr", 64'(out_instr), 64'(head[31:0]));
      end
      if (stalled_prev) chk("stable", {out_pc_plus4, out_instr}, prev_out);
      stalled_prev = (n > 0) && !out_ready && !flush;
      prev_out     = {out_pc_plus4, out_instr};
      if (flush) begin
        sb_q.delete();
        stall_m = 0;
      end else begin
        if (n > 0 && out_ready) begin
          void'(sb_q.pop_front());
          $display("xfer out pc=%08h instr=%08h", out_pc_plus4, out_instr);
          stall_m = 0;
        end else if (n > 0 && stall_m < SMAX) begin
          stall_m++;
        end
        if (in_valid && n < 2) sb_q.push_back({in_pc_plus4, in_instr});
      end
    end
  end

  logic [31:0] pc_ctr = 32'h0000_1004;

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus4 = pc_ctr;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc_plus4 = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_instr", 64'(out_instr), 64'(NOP));
    chk("rst_pc", 64'(out_pc_plus4), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Streaming
    drive(1, 32'hA000_0001, 1, 0);
    chk("stream_lat", 64'(out_valid), 64'd1);
    drive(1, 32'hB000_0002, 1, 0);
    drive(1, 32'hC000_0003, 1, 0);
    drive(1, 32'hD000_0004, 1, 0);
    chk("stream_last", 64'(out_instr), 64'hD000_0004);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Back-pressure into skid
    drive(1, 32'hA100_0001, 1, 0);
    drive(1, 32'hB100_0002, 0, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    chk("bp_hold_a", 64'(out_instr), 64'hA100_0001);
    drive(0, 32'h0, 1, 0);
    chk("bp_b_next", 64'(out_instr), 64'hB100_0002);
    chk("bp_clr", 64'(stall_cnt), 64'd0);
    drive(0, 32'h0, 1, 0);

    // Flush while in SKID with C offered
    drive(1, 32'hA200_0001, 0, 0);
    drive(1, 32'hB200_0002, 0, 0);
    drive(1, 32'hC200_0003, 0, 1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_nop", 64'(out_instr), 64'(NOP));
    chk("fl_ready", 64'(in_ready), 64'd1);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Saturation
    drive(1, 32'h5A70_0000, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 32'h0, 0, 0);
    chk("sat7", 64'(stall_cnt), 64'd7);
    drive(0, 32'h0, 0, 1);

    // Bubble from FULL
    drive(1, 32'hBBB0_0001, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_nop", 64'(out_instr), 64'(NOP));
    chk("bub_stall", 64'(stall_cnt), 64'd0);

    // Async reset mid-cycle while in SKID
    drive(1, 32'hA300_0001, 0, 0);
    drive(1, 32'hB300_0002, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_nop", 64'(out_instr), 64'(NOP));
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'hEEEE_0005, 1, 0);
    chk("arst_e_lat", 64'(out_valid), 64'd1);
    chk("arst_e_instr", 64'(out_instr), 64'hEEEE_0005);
    drive(0, 32'h0, 1, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) < 70), $urandom(),
            ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 4));
    end
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
